// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types for the write-back stage.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = $clog2(NREGS);

   typedef enum logic {
      WB_SEL_ALU = 1'b0,
      WB_SEL_MEM = 1'b1
   } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: one write port, two combinational read ports, x0 hardwired to zero.
module regfile_2r1w
   import riscv_pkg::*;
#(
   parameter int XLEN_P  = XLEN,
   parameter int NREGS_P = NREGS,
   parameter int AW      = $clog2(NREGS_P)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN_P-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN_P-1:0] rdata1,
   output logic [XLEN_P-1:0] rdata2
);

   logic [XLEN_P-1:0] regs_q [NREGS_P];
   logic [XLEN_P-1:0] regs_d [NREGS_P];

   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   // NOTE: the whole array is cleared on reset because architectural state must read 0 immediately after rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS_P; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result select, register file commit, forward record and commit counter.
// Optional write-first read bypass enabled by defining WB_BYPASS_EN.
module writeback_regfile
   import riscv_pkg::*;
#(
   parameter int XLEN_P  = XLEN,
   parameter int NREGS_P = NREGS,
   parameter int AW      = $clog2(NREGS_P)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN_P-1:0] mem_read_data,
   input  logic [XLEN_P-1:0] alu_out,
   input  logic [AW-1:0]     rd,
   input  logic              writeback,
   input  logic              register_write_enable,
   input  logic [AW-1:0]     rs1_addr,
   input  logic [AW-1:0]     rs2_addr,
   output logic [XLEN_P-1:0] rs1_data,
   output logic [XLEN_P-1:0] rs2_data,
   output logic [XLEN_P-1:0] wb_data,
   output logic              fwd_valid,
   output logic [AW-1:0]     fwd_rd,
   output logic [XLEN_P-1:0] fwd_data,
   output logic [31:0]       wb_count
);

   logic              commit;
   logic [XLEN_P-1:0] arr_rs1;
   logic [XLEN_P-1:0] arr_rs2;

   logic              fwd_valid_q, fwd_valid_d;
   logic [AW-1:0]     fwd_rd_q,    fwd_rd_d;
   logic [XLEN_P-1:0] fwd_data_q,  fwd_data_d;
   logic [31:0]       wb_count_q,  wb_count_d;

   assign wb_data = (wb_sel_e'(writeback) == WB_SEL_MEM) ? mem_read_data : alu_out;
   assign commit  = register_write_enable && (rd != '0);

   regfile_2r1w #(
      .XLEN_P  (XLEN_P),
      .NREGS_P (NREGS_P),
      .AW      (AW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (commit),
      .waddr  (rd),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (arr_rs1),
      .rdata2 (arr_rs2)
   );

`ifdef WB_BYPASS_EN
   // x0 never matches because commit already excludes rd=0.
   assign rs1_data = (commit && (rd == rs1_addr)) ? wb_data : arr_rs1;
   assign rs2_data = (commit && (rd == rs2_addr)) ? wb_data : arr_rs2;
`else
   assign rs1_data = arr_rs1;
   assign rs2_data = arr_rs2;
`endif

   // NOTE: next-state logic is combinational, so it uses blocking assignments; only the flops below use <=.
   always_comb begin
      fwd_valid_d = commit;
      fwd_rd_d    = rd;
      fwd_data_d  = wb_data;
      wb_count_d  = wb_count_q;
      if (commit) begin
         wb_count_d = wb_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_valid_q <= 1'b0;
         fwd_rd_q    <= '0;
         fwd_data_q  <= '0;
         wb_count_q  <= '0;
      end else begin
         fwd_valid_q <= fwd_valid_d;
         fwd_rd_q    <= fwd_rd_d;
         fwd_data_q  <= fwd_data_d;
         wb_count_q  <= wb_count_d;
      end
   end

   assign fwd_valid = fwd_valid_q;
   assign fwd_rd    = fwd_rd_q;
   assign fwd_data  = fwd_data_q;
   assign wb_count  = wb_count_q;

endmodule
